tt_pin_host: RTL and testbench

TT_PIN_HOST -- requirements
Module: tt_pin_host

---
 rtl/tt_pin_host.sv | 171 +++++++++++++++++
 tb/tb_tt_pin_host.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_pin_host.sv
// -----------------------------------------------------------------------------
// tt_pin_host
//
// Host-side bridge that carries one register command to a pin-limited chip.
// Each command is a header byte {write, addr[6:0]} and then a data byte. Both
// bytes are sent with a 4-phase req/ack handshake on pin_req/pin_ack. On a
// read, the byte the chip drives on pin_rdata is captured while the data-phase
// ack is high. The block aborts with an error response if the chip stays in
// any ack-wait state for TIMEOUT cycles.
//
// Parameters
//   TIMEOUT      cycles allowed in each ack-wait state before abort (1..65535)
//   SYNC_STAGES  flop count of the pin_ack synchronizer (2..3)
//
// Ports
//   clk, rst_n            single rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake, accepted when both are high
//   cmd_write/addr/wdata  command fields, registered at acceptance
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata/rsp_error   response payload, zero whenever rsp_valid is low
//   pin_data/pin_req      byte and request driven to the chip
//   pin_ack/pin_rdata     acknowledge (asynchronous) and read byte from chip
// -----------------------------------------------------------------------------
module tt_pin_host #(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic [7:0] pin_data,
  output logic       pin_req,
  input  logic       pin_ack,
  input  logic [7:0] pin_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_REQ,
    HDR_REL,
    DAT_REQ,
    DAT_REL,
    ABORT,
    RSP
  } state_t;

  // The wait in cycle k of a wait state sees cnt == k-1, so the abort decision
  // is taken at the end of cycle TIMEOUT.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [SYNC_STAGES-1:0]  ack_sync;
  logic                    ack_s;
  logic [15:0]             cnt;
  logic                    expired;
  logic                    accept;

  logic                    wr_q;
  logic [6:0]              addr_q;
  logic [7:0]              wdata_q;
  logic [7:0]              rd_q;

  // Command fields as they will be after this edge; lets the registered pin
  // outputs show the new header in the very first HDR_REQ cycle.
  logic                    wr_n;
  logic [6:0]              addr_n;
  logic [7:0]              wdata_n;

  logic [7:0]              pin_data_nxt;
  logic                    wait_nxt;

  assign ack_s   = ack_sync[SYNC_STAGES-1];
  assign expired = (cnt == CNT_LAST);
  assign accept  = cmd_valid & cmd_ready;

  assign wr_n    = accept ? cmd_write : wr_q;
  assign addr_n  = accept ? cmd_addr  : addr_q;
  assign wdata_n = accept ? cmd_wdata : wdata_q;

  // ---------------------------------------------------------------------------
  // Next-state logic. The awaited ack level is tested before the timeout so an
  // ack arriving on the last allowed cycle completes normally.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case statement leaves it unassigned and infers a latch.
    state_nxt    = state;
    pin_data_nxt = 8'h00;

    unique case (state)
      IDLE:    if (accept)  state_nxt = HDR_REQ;
      HDR_REQ: if (ack_s)   state_nxt = HDR_REL;
               else if (expired) state_nxt = ABORT;
      HDR_REL: if (!ack_s)  state_nxt = DAT_REQ;
               else if (expired) state_nxt = ABORT;
      DAT_REQ: if (ack_s)   state_nxt = DAT_REL;
               else if (expired) state_nxt = ABORT;
      DAT_REL: if (!ack_s)  state_nxt = RSP;
               else if (expired) state_nxt = ABORT;
      ABORT:   if (!ack_s)  state_nxt = RSP;
      RSP:                  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase

    unique case (state_nxt)
      HDR_REQ, HDR_REL: pin_data_nxt = {wr_n, addr_n};
      DAT_REQ, DAT_REL: pin_data_nxt = wr_n ? wdata_n : 8'h00;
      default:          pin_data_nxt = 8'h00;
    endcase
  end

  assign wait_nxt = (state_nxt == HDR_REQ) || (state_nxt == HDR_REL) ||
                    (state_nxt == DAT_REQ) || (state_nxt == DAT_REL);

  // ---------------------------------------------------------------------------
  // State, counter, synchronizer, command fields and registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: every flop here, including the data-path registers, takes the async
  // reset so a mid-transaction reset leaves no stale byte behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ack_sync  <= '0;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      cmd_ready <= 1'b0;
      pin_req   <= 1'b0;
      pin_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state    <= state_nxt;
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], pin_ack};

      if (state_nxt != state && wait_nxt) cnt <= '0;
      else if (wait_nxt)                  cnt <= cnt + 16'd1;
      else                                cnt <= '0;

      if (accept) begin
        wr_q    <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        rd_q    <= '0;
      end else if (state == DAT_REQ && ack_s && !wr_q) begin
        rd_q <= pin_rdata;
      end

      cmd_ready <= (state_nxt == IDLE);
      pin_req   <= (state_nxt == HDR_REQ) || (state_nxt == DAT_REQ);
      pin_data  <= pin_data_nxt;
      rsp_valid <= (state_nxt == RSP);
      // RSP is reached either from ABORT (error) or from DAT_REL (success).
      rsp_error <= (state_nxt == RSP) && (state == ABORT);
      rsp_rdata <= ((state_nxt == RSP) && (state == DAT_REL) && !wr_q) ? rd_q : 8'h00;
    end
  end

endmodule

// File: tb/tb_tt_pin_host.sv
// -----------------------------------------------------------------------------
// tb_tt_pin_host
//
// Directed bench for tt_pin_host with TIMEOUT=8, SYNC_STAGES=2. A table of
// complete transactions is run against a reactive chip model, followed by
// hand-written sequences for timeout, ack-versus-timeout races, reset in the
// middle of a transaction and back-to-back commands.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tt_pin_host;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic [7:0] pin_data;
  logic       pin_req;
  logic       pin_ack;
  logic [7:0] pin_rdata;

  tt_pin_host #(.TIMEOUT(TO), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .pin_data  (pin_data),
    .pin_req   (pin_req),
    .pin_ack   (pin_ack),
    .pin_rdata (pin_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_hi;

  typedef struct {
    logic       w;
    logic [6:0] a;
    logic [7:0] wd;
    logic [7:0] crd;
    int         dly;
    logic [7:0] e_hdr;
    logic [7:0] e_dat;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a command and return on the negedge after it was accepted
  // (first cycle of HDR_REQ). cmd_valid stays high when hold is set.
  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, input bit hold);
    int n = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_accept", cmd_ready, 1);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Chip side of one 4-phase cycle: wait for req, capture the byte, ack after
  // dly cycles with rd on pin_rdata, drop ack once req falls.
  task automatic chip_phase(input int dly, input logic [7:0] rd, output logic [7:0] seen);
    int n = 0;
    while (!pin_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("pin_req_rise", pin_req, 1);
    seen = pin_data;
    repeat (dly) begin
      if (cmd_ready) ready_hi++;
      @(negedge clk);
    end
    pin_ack   = 1'b1;
    pin_rdata = rd;
    n = 0;
    while (pin_req && n < 40) begin
      if (cmd_ready) ready_hi++;
      @(negedge clk);
      n++;
    end
    check("pin_req_fall", pin_req, 0);
    pin_ack   = 1'b0;
    pin_rdata = 8'hEE;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 40) begin
      if (cmd_ready) ready_hi++;
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", rsp_valid, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] hdr, dat;
    ready_hi = 0;
    send(v.w, v.a, v.wd, 1'b0);
    chip_phase(v.dly, 8'h00, hdr);
    chip_phase(v.dly, v.crd, dat);
    wait_rsp();
    check($sformatf("v%0d_hdr", idx), hdr, v.e_hdr);
    check($sformatf("v%0d_dat", idx), dat, v.e_dat);
    check($sformatf("v%0d_rsp_error", idx), rsp_error, 0);
    check($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.e_rd);
    check($sformatf("v%0d_ready_low", idx), ready_hi, 0);
    @(negedge clk);
    check($sformatf("v%0d_rsp_pulse_end", idx), rsp_valid, 0);
    check($sformatf("v%0d_rdata_zero", idx), rsp_rdata, 0);
    check($sformatf("v%0d_ready_back", idx), cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int cnt_hi;
    int n;

    //           w     addr   wdata  chip_rd dly  hdr    dat    rdata
    vecs[0] = '{1'b1, 7'h15, 8'hA7, 8'h33, 3, 8'h95, 8'hA7, 8'h00};
    vecs[1] = '{1'b0, 7'h02, 8'hFF, 8'h5C, 3, 8'h02, 8'h00, 8'h5C};
    vecs[2] = '{1'b1, 7'h7F, 8'hFF, 8'h11, 0, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{1'b0, 7'h00, 8'hC3, 8'hA5, 1, 8'h00, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 7'h2A, 8'h5A, 8'h00, 4, 8'hAA, 8'h5A, 8'h00};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pin_ack   = 1'b0;
    pin_rdata = 8'hEE;

    // Reset values, then cmd_ready on the first edge after release.
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_pin_req", pin_req, 0);
    check("rst_pin_data", pin_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("ready_low_at_release", cmd_ready, 0);
    @(negedge clk);
    check("ready_first_edge", cmd_ready, 1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Timeout in HDR_REQ: chip never acks.
    send(1'b1, 7'h21, 8'h44, 1'b0);
    cnt_hi = 0;
    for (int k = 0; k < TO; k++) begin
      if (pin_req) cnt_hi++;
      @(negedge clk);
    end
    check("to_req_cycles", cnt_hi, TO);
    check("to_req_low", pin_req, 0);
    check("to_data_zero", pin_data, 0);
    check("to_ready_low", cmd_ready, 0);
    @(negedge clk);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_error", rsp_error, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    check("to_rsp_end", rsp_valid, 0);
    check("to_error_end", rsp_error, 0);
    check("to_ready_back", cmd_ready, 1);

    // Ack synced in cycle TIMEOUT of DAT_REQ: ack wins.
    send(1'b1, 7'h33, 8'h5A, 1'b0);
    chip_phase(2, 8'h00, b);
    check("race_win_hdr", b, 8'hB3);
    n = 0;
    while (!pin_req && n < 40) begin @(negedge clk); n++; end
    check("race_win_dat_req", pin_req, 1);
    repeat (5) @(negedge clk);
    pin_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("race_win_req_low", pin_req, 0);
    check("race_win_data_held", pin_data, 8'h5A);
    pin_ack = 1'b0;
    wait_rsp();
    check("race_win_error", rsp_error, 0);
    check("race_win_rdata", rsp_rdata, 0);
    @(negedge clk);

    // Ack synced one cycle too late: ABORT, held until ack falls.
    send(1'b0, 7'h0C, 8'h00, 1'b0);
    chip_phase(2, 8'h00, b);
    check("race_late_hdr", b, 8'h0C);
    n = 0;
    while (!pin_req && n < 40) begin @(negedge clk); n++; end
    check("race_late_dat_req", pin_req, 1);
    repeat (6) @(negedge clk);
    pin_ack   = 1'b1;
    pin_rdata = 8'h77;
    repeat (2) @(negedge clk);
    check("race_late_req_low", pin_req, 0);
    check("race_late_data_zero", pin_data, 0);
    cnt_hi = 0;
    repeat (6) begin
      if (rsp_valid) cnt_hi++;
      @(negedge clk);
    end
    check("race_late_abort_held", cnt_hi, 0);
    pin_ack   = 1'b0;
    pin_rdata = 8'hEE;
    wait_rsp();
    check("race_late_error", rsp_error, 1);
    check("race_late_rdata", rsp_rdata, 0);
    @(negedge clk);

    // Reset asserted during DAT_REQ.
    send(1'b1, 7'h40, 8'hC8, 1'b0);
    chip_phase(1, 8'h00, b);
    n = 0;
    while (!pin_req && n < 40) begin @(negedge clk); n++; end
    check("mid_rst_in_dat_req", pin_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pin_req", pin_req, 0);
    check("mid_rst_pin_data", pin_data, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    cnt_hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) cnt_hi++;
    end
    check("mid_rst_no_rsp", cnt_hi, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", cmd_ready, 1);
    run_vec(vecs[1], 5);

    // Back-to-back with cmd_valid held high.
    ready_hi = 0;
    send(1'b1, 7'h10, 8'h01, 1'b1);
    cmd_write = 1'b0;
    cmd_addr  = 7'h44;
    cmd_wdata = 8'h00;
    chip_phase(1, 8'h00, b);
    check("b2b_a_hdr", b, 8'h90);
    chip_phase(1, 8'h00, b);
    check("b2b_a_dat", b, 8'h01);
    wait_rsp();
    check("b2b_a_error", rsp_error, 0);
    check("b2b_ready_at_rsp", cmd_ready, 0);
    check("b2b_a_ready_low", ready_hi, 0);
    @(negedge clk);
    check("b2b_ready_after_rsp", cmd_ready, 1);
    @(negedge clk);
    check("b2b_b_req", pin_req, 1);
    check("b2b_b_hdr", pin_data, 8'h44);
    check("b2b_b_ready_low", cmd_ready, 0);
    cmd_valid = 1'b0;
    chip_phase(1, 8'h00, b);
    chip_phase(1, 8'h9B, b);
    check("b2b_b_dat", b, 8'h00);
    wait_rsp();
    check("b2b_b_rdata", rsp_rdata, 8'h9B);
    check("b2b_b_error", rsp_error, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
